// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl: multi-cycle instruction sequencer for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB. It owns the
// imem/dmem request handshakes, the PC and register-file write strobes, and
// halt/fault reporting.
//
// Optional build macro: EXEC_SEQ_PERF_EN adds the cycle_cnt and instret_cnt
// performance counter outputs.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | just out of reset, all outputs low, always moves to FETCH
// FETCH  | imem_req high, waiting for imem_ready (timeout -> fault 2)
// DECODE | id_en pulse, illegal opcode -> HALT with fault 1
// EXEC   | ex_en pulse, datapath registers alu_result/pc_next
// MEM    | dmem_req high, waiting for dmem_ready (timeout -> fault 3)
// WB     | pc_we pulse, rf_we for instructions that write rd
// HALT   | halted high, fault code held, left only through reset
//
// Outputs decode combinationally from the state register and current inputs,
// so an asynchronous reset drops every strobe immediately.

module exec_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_reg_write,
  input  logic        dec_illegal,
  output logic        imem_req,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halted,
`ifdef EXEC_SEQ_PERF_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt,
`endif
  output logic [1:0]  fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_IMEM    = 2'd2;
  localparam logic [1:0] FAULT_DMEM    = 2'd3;

  // The timeout fires on the wait cycle whose increment would reach the limit,
  // i.e. after exactly TIMEOUT_CYCLES cycles without ready.
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMO_W-1:0] wait_cnt;
  logic             tmo_hit;

  assign tmo_hit = TMO_EN && (wait_cnt == TMO_LAST);

  // Sequencer state, wait counter and sticky fault code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      fault    <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_FETCH: begin
          // ready wins over a timeout landing in the same cycle
          if (imem_ready) begin
            state    <= S_DECODE;
            wait_cnt <= '0;
          end else if (tmo_hit) begin
            state    <= S_HALT;
            fault    <= FAULT_IMEM;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          if (dec_illegal) begin
            state <= S_HALT;
            fault <= FAULT_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (dec_is_load || dec_is_store) state <= S_MEM;
          else                             state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            state    <= S_WB;
            wait_cnt <= '0;
          end else if (tmo_hit) begin
            state    <= S_HALT;
            fault    <= FAULT_DMEM;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_HALT: begin
          state    <= S_HALT;
          wait_cnt <= '0;
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Stage enables and handshake strobes decoded from the current state.
  always_comb begin
    imem_req = 1'b0;
    if_en    = 1'b0;
    id_en    = 1'b0;
    ex_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if_en    = imem_ready;
      end
      S_DECODE: id_en = 1'b1;
      S_EXEC:   ex_en = 1'b1;
      S_MEM: begin
        dmem_req = 1'b1;
        // load+store together is treated as a store
        dmem_we  = dec_is_store;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = dec_reg_write && !dec_is_store;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

`ifdef EXEC_SEQ_PERF_EN
  // Performance counters: active cycles and retired instructions, frozen in HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state != S_IDLE && state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (state == S_WB) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed vector bench for exec_seq_ctrl (built with TIMEOUT_CYCLES=4).
// Each vector drives inputs on the falling edge and checks the decoded outputs
// two time units later, before the next rising edge.
module tb_exec_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0;
  logic dec_is_load = 1'b0, dec_is_store = 1'b0;
  logic dec_reg_write = 1'b0, dec_illegal = 1'b0;
  logic imem_req, if_en, id_en, ex_en, dmem_req, dmem_we, pc_we, rf_we, halted;
  logic [1:0] fault;
`ifdef EXEC_SEQ_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  exec_seq_ctrl #(.TIMEOUT_CYCLES(4), .TMO_W(16)) dut (
    .clk(clk), .rst(rst),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_reg_write(dec_reg_write), .dec_illegal(dec_illegal),
    .imem_req(imem_req), .if_en(if_en), .id_en(id_en), .ex_en(ex_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_we(pc_we), .rf_we(rf_we),
    .halted(halted),
`ifdef EXEC_SEQ_PERF_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .fault(fault)
  );

  // {imem_req, if_en, id_en, ex_en, dmem_req, dmem_we, pc_we, rf_we, halted, fault[1:0]}
  localparam logic [10:0] X_IDLE  = 11'b00000000000;
  localparam logic [10:0] X_FRDY  = 11'b11000000000;
  localparam logic [10:0] X_FWAIT = 11'b10000000000;
  localparam logic [10:0] X_DEC   = 11'b00100000000;
  localparam logic [10:0] X_EXEC  = 11'b00010000000;
  localparam logic [10:0] X_MRD   = 11'b00001000000;
  localparam logic [10:0] X_MWR   = 11'b00001100000;
  localparam logic [10:0] X_WBRF  = 11'b00000011000;
  localparam logic [10:0] X_WB    = 11'b00000010000;
  localparam logic [10:0] X_HLT1  = 11'b00000000101;
  localparam logic [10:0] X_HLT2  = 11'b00000000110;
  localparam logic [10:0] X_HLT3  = 11'b00000000111;

  typedef struct {
    logic        rst, im, dm, ld, st, rw, ill;
    logic [10:0] exp;
    logic        chk_perf;
    logic [31:0] exp_cyc, exp_ins;
  } vec_t;

  vec_t vecs[$];
  int   vec_cnt = 0;
  int   miscompares = 0;

  function automatic logic [10:0] outs();
    return {imem_req, if_en, id_en, ex_en, dmem_req, dmem_we, pc_we, rf_we, halted, fault};
  endfunction

  task automatic add(input logic r, im, dm, ld, st, rw, ill, input logic [10:0] e);
    vec_t v;
    v.rst = r; v.im = im; v.dm = dm; v.ld = ld; v.st = st; v.rw = rw; v.ill = ill;
    v.exp = e; v.chk_perf = 1'b0; v.exp_cyc = 32'd0; v.exp_ins = 32'd0;
    vecs.push_back(v);
  endtask

  task automatic mark_perf(input logic [31:0] cyc, input logic [31:0] ins);
    vec_t v;
    v = vecs.pop_back();
    v.chk_perf = 1'b1; v.exp_cyc = cyc; v.exp_ins = ins;
    vecs.push_back(v);
  endtask

  task automatic check_perf(input string name, input logic [31:0] cyc, input logic [31:0] ins);
`ifdef EXEC_SEQ_PERF_EN
    vec_cnt++;
    if (cycle_cnt !== cyc || instret_cnt !== ins) begin
      miscompares++;
      $display("FAIL %s perf got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
               name, cycle_cnt, instret_cnt, cyc, ins);
    end
`else
    if (name.len() == 0 && cyc == ins) ;
`endif
  endtask

  initial begin
    // reset, then two ALU ops with imem_ready tied high
    add(0,0,0,0,0,0,0, X_IDLE);
    add(1,1,0,0,0,1,0, X_IDLE);
    add(1,1,0,0,0,1,0, X_FRDY);
    add(1,1,0,0,0,1,0, X_DEC);
    add(1,1,0,0,0,1,0, X_EXEC);
    add(1,1,0,0,0,1,0, X_WBRF);
    add(1,1,0,0,0,1,0, X_FRDY);
    add(1,1,0,0,0,1,0, X_DEC);
    add(1,1,0,0,0,1,0, X_EXEC);
    add(1,1,0,0,0,1,0, X_WBRF);
    // load with dmem_ready delayed 3 cycles
    add(1,1,0,0,0,1,0, X_FRDY);  mark_perf(32'd8, 32'd2);
    add(1,1,0,1,0,1,0, X_DEC);
    add(1,1,0,1,0,1,0, X_EXEC);
    add(1,0,0,1,0,1,0, X_MRD);
    add(1,0,0,1,0,1,0, X_MRD);
    add(1,0,0,1,0,1,0, X_MRD);
    add(1,0,1,1,0,1,0, X_MRD);
    add(1,0,0,1,0,1,0, X_WBRF);
    // store, immediate dmem_ready, dec_reg_write set but suppressed
    add(1,1,0,0,1,1,0, X_FRDY);
    add(1,1,0,0,1,1,0, X_DEC);
    add(1,1,0,0,1,1,0, X_EXEC);
    add(1,0,1,0,1,1,0, X_MWR);
    add(1,0,0,0,1,1,0, X_WB);
    // load and store both set behaves as a store
    add(1,1,0,1,1,1,0, X_FRDY);
    add(1,1,0,1,1,1,0, X_DEC);
    add(1,1,0,1,1,1,0, X_EXEC);
    add(1,0,1,1,1,1,0, X_MWR);
    add(1,0,0,1,1,1,0, X_WB);
    // imem_ready on the 4th wait cycle wins over the timeout; dmem_ready ignored
    add(1,0,1,0,0,1,0, X_FWAIT);
    add(1,0,1,0,0,1,0, X_FWAIT);
    add(1,0,1,0,0,1,0, X_FWAIT);
    add(1,1,1,0,0,1,0, X_FRDY);
    add(1,1,1,0,0,1,0, X_DEC);
    add(1,1,1,0,0,1,0, X_EXEC);
    add(1,1,1,0,0,1,0, X_WBRF);
    // reset during MEM drops dmem_req at once
    add(1,1,0,0,0,1,0, X_FRDY);
    add(1,1,0,1,0,1,0, X_DEC);
    add(1,1,0,1,0,1,0, X_EXEC);
    add(1,0,0,1,0,1,0, X_MRD);
    add(0,0,0,1,0,1,0, X_IDLE);
    add(1,0,0,0,0,1,0, X_IDLE);  mark_perf(32'd0, 32'd0);
    // imem timeout after 4 wait cycles
    add(1,0,0,0,0,1,0, X_FWAIT);
    add(1,0,0,0,0,1,0, X_FWAIT);
    add(1,0,0,0,0,1,0, X_FWAIT);
    add(1,0,0,0,0,1,0, X_FWAIT);
    add(1,0,0,0,0,1,0, X_HLT2);
    add(1,1,1,0,0,1,0, X_HLT2);  mark_perf(32'd4, 32'd0);
    // dmem timeout after 4 wait cycles
    add(0,0,0,0,0,0,0, X_IDLE);
    add(1,1,0,0,0,1,0, X_IDLE);
    add(1,1,0,1,0,1,0, X_FRDY);
    add(1,1,0,1,0,1,0, X_DEC);
    add(1,0,0,1,0,1,0, X_EXEC);
    add(1,0,0,1,0,1,0, X_MRD);
    add(1,0,0,1,0,1,0, X_MRD);
    add(1,0,0,1,0,1,0, X_MRD);
    add(1,0,0,1,0,1,0, X_MRD);
    add(1,0,1,1,0,1,0, X_HLT3);
    // illegal instruction
    add(0,0,0,0,0,0,0, X_IDLE);
    add(1,1,0,0,0,1,1, X_IDLE);
    add(1,1,0,0,0,1,1, X_FRDY);
    add(1,1,0,0,0,1,1, X_DEC);
    add(1,1,1,0,1,1,1, X_HLT1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      imem_ready = vecs[i].im;     dmem_ready = vecs[i].dm;
      dec_is_load = vecs[i].ld;    dec_is_store = vecs[i].st;
      dec_reg_write = vecs[i].rw;  dec_illegal = vecs[i].ill;
      #2;
      vec_cnt++;
      if (outs() !== vecs[i].exp) begin
        miscompares++;
        $display("FAIL vec%0d outputs got %b expected %b", i, outs(), vecs[i].exp);
      end
      if (vecs[i].chk_perf) check_perf($sformatf("vec%0d", i), vecs[i].exp_cyc, vecs[i].exp_ins);
    end

    // HALT is sticky under arbitrary inputs; no pc_we/rf_we ever
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      imem_ready = 1'($urandom_range(0, 1));   dmem_ready = 1'($urandom_range(0, 1));
      dec_is_load = 1'($urandom_range(0, 1));  dec_is_store = 1'($urandom_range(0, 1));
      dec_reg_write = 1'($urandom_range(0, 1)); dec_illegal = 1'($urandom_range(0, 1));
      #2;
      vec_cnt++;
      if (outs() !== X_HLT1) begin
        miscompares++;
        $display("FAIL halt_hold cycle %0d got %b expected %b", c, outs(), X_HLT1);
      end
    end
    check_perf("halt_freeze", 32'd2, 32'd0);

    // reset asserted mid-cycle while in MEM
    @(negedge clk); rst = 1'b0; #2;
    @(negedge clk); rst = 1'b1;
    imem_ready = 1'b1; dmem_ready = 1'b0; dec_is_load = 1'b1; dec_is_store = 1'b0;
    dec_reg_write = 1'b1; dec_illegal = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    vec_cnt++;
    if (outs() !== X_MRD) begin
      miscompares++;
      $display("FAIL mid_mem_pre got %b expected %b", outs(), X_MRD);
    end
    @(posedge clk); #3;
    rst = 1'b0; #1;
    vec_cnt++;
    if (outs() !== X_IDLE) begin
      miscompares++;
      $display("FAIL mid_mem_rst got %b expected %b", outs(), X_IDLE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
